// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush sequencer for a 5-stage MIPS pipeline: load-use bubbles,
// taken-branch IF/ID flush, data-memory wait hold, stall counter and timeout flag.
module hazard_stall_controller #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ctrl_sel,
  output logic             IF_ID_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [3:0]        LU_RELOAD = 4'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic lu, memwait;
  logic pcw, ifw, csel, flush, hold;

  always_comb begin
    lu = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
         ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
    memwait = mem_req && !mem_ready;

    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    pcw   = 1'b1;
    ifw   = 1'b1;
    csel  = 1'b1;
    flush = 1'b0;
    hold  = 1'b0;

    if (memwait) begin
      // Whole pipe frozen: bubble sequencing resumes untouched afterwards.
      hold = 1'b1;
      pcw  = 1'b0;
      ifw  = 1'b0;
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
      if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
    end else if (state_q == LU_STALL) begin
      pcw  = 1'b0;
      ifw  = 1'b0;
      csel = 1'b0;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = RUN;
    end else if (lu) begin
      pcw  = 1'b0;
      ifw  = 1'b0;
      csel = 1'b0;
      if (LOAD_USE_STALLS > 1) begin
        state_d = LU_STALL;
        cnt_d   = LU_RELOAD;
      end
    end else if (branch_taken) begin
      flush = 1'b1;
    end

    stall_count_d = (!pcw && (stall_count_q != '1)) ? stall_count_q + CNT_ONE
                                                    : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Control outputs are forced low while reset is held.
  assign pc_write    = rst_n & pcw;
  assign IF_ID_write = rst_n & ifw;
  assign ctrl_sel    = rst_n & csel;
  assign IF_ID_flush = rst_n & flush;
  assign pipe_hold   = rst_n & hold;
  assign stall_count = stall_count_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two configurations (1 stall / 3 stalls with
// short timeout and narrow counter), directed scenarios plus a randomized run.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read, uses_rt, br, mreq, mrdy;
  logic [4:0] ex_rt, rs, rt;

  logic pcw1, ifw1, cs1, fl1, ph1, mt1;
  logic [15:0] sc1;
  logic pcw3, ifw3, cs3, fl3, ph3, mt3;
  logic [3:0] sc3;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining bubbles, mem-wait run length, stall tally, sticky flag
  int LUS[2]  = '{1, 3};
  int MT[2]   = '{64, 4};
  int CMAX[2] = '{65535, 15};
  int bub[2], wrun[2], cnt[2];
  bit to[2];

  always #5 clk = ~clk;

  hazard_stall_controller #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(64), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt),
    .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_uses_rt(uses_rt), .branch_taken(br),
    .mem_req(mreq), .mem_ready(mrdy), .pc_write(pcw1), .IF_ID_write(ifw1),
    .ctrl_sel(cs1), .IF_ID_flush(fl1), .pipe_hold(ph1), .stall_count(sc1),
    .mem_timeout(mt1));

  hazard_stall_controller #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(4), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt),
    .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_uses_rt(uses_rt), .branch_taken(br),
    .mem_req(mreq), .mem_ready(mrdy), .pc_write(pcw3), .IF_ID_write(ifw3),
    .ctrl_sel(cs3), .IF_ID_flush(fl3), .pipe_hold(ph3), .stall_count(sc3),
    .mem_timeout(mt3));

  function automatic bit is_lu();
    return mem_read && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  endfunction

  // Expected {pc_write, IF_ID_write, ctrl_sel, IF_ID_flush, pipe_hold}
  function automatic logic [4:0] mexp(int k);
    if (mreq && !mrdy) return 5'b00101;
    if (bub[k] > 0 || is_lu()) return 5'b00000;
    if (br) return 5'b11110;
    return 5'b11100;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bub[k] = 0; wrun[k] = 0; cnt[k] = 0; to[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] e;
      e = mexp(k);
      if (!e[4] && cnt[k] < CMAX[k]) cnt[k]++;
      if (mreq && !mrdy) begin
        if (wrun[k] < MT[k]) wrun[k]++;
        if (wrun[k] == MT[k]) to[k] = 1;
      end else begin
        wrun[k] = 0;
        if (bub[k] > 0) bub[k]--;
        else if (is_lu()) bub[k] = LUS[k] - 1;
      end
    end
  endtask

  task automatic set_idle();
    mem_read = 0; ex_rt = 0; rs = 0; rt = 0; uses_rt = 0; br = 0; mreq = 0; mrdy = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
  endtask

  task automatic set_lu();
    mem_read = 1; ex_rt = 5'd8; rs = 5'd8;
  endtask

  task automatic test_reset();
    set_idle();
    #2;
    checks++;
    if ({pcw1, ifw1, cs1, fl1, ph1, pcw3, ifw3, cs3, fl3, ph3} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b%b%b%b%b %b%b%b%b%b want all 0",
               pcw1, ifw1, cs1, fl1, ph1, pcw3, ifw3, cs3, fl3, ph3);
    end
    checks++;
    if (sc1 !== 16'd0 || sc3 !== 4'd0 || mt1 !== 1'b0 || mt3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_counters: sc1=%0d sc3=%0d mt1=%b mt3=%b want 0", sc1, sc3, mt1, mt3);
    end
    // Reset asserted in the middle of a 3-deep load-use stall
    do_reset();
    set_lu();
    tick();
    set_idle();
    checks++;
    if (pcw3 !== 1'b0 || cs3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_lu_stall: pc_write=%b ctrl_sel=%b want 0 0", pcw3, cs3);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({pcw3, ifw3, cs3, fl3, ph3} !== 5'b0 || sc3 !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_stall: ctrl=%b sc3=%0d want 00000 0", {pcw3, ifw3, cs3, fl3, ph3}, sc3);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (pcw3 !== 1'b1 || cs3 !== 1'b1 || sc3 !== 4'd0) begin
      failures++;
      $display("FAIL reset_release: pc_write=%b ctrl_sel=%b sc3=%0d want 1 1 0", pcw3, cs3, sc3);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    @(negedge clk);
    checks++;
    if ({pcw1, ifw1, cs1, fl1, ph1} !== 5'b00000) begin
      failures++;
      $display("FAIL load_use_bubble: ctrl=%b want 00000", {pcw1, ifw1, cs1, fl1, ph1});
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if ({pcw1, ifw1, cs1, fl1, ph1} !== 5'b11100 || sc1 !== 16'd1) begin
      failures++;
      $display("FAIL load_use_after: ctrl=%b sc1=%0d want 11100 1", {pcw1, ifw1, cs1, fl1, ph1}, sc1);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    do_reset();
    mem_read = 1; ex_rt = 0; rs = 0;
    @(negedge clk);
    checks++;
    if (cs1 !== 1'b1 || pcw1 !== 1'b1 || cs3 !== 1'b1) begin
      failures++;
      $display("FAIL no_hazard_r0: ctrl_sel=%b/%b pc_write=%b want 1", cs1, cs3, pcw1);
    end
    tick();
    ex_rt = 5'd9; rt = 5'd9; rs = 5'd3; uses_rt = 0;
    @(negedge clk);
    checks++;
    if (cs1 !== 1'b1 || pcw1 !== 1'b1) begin
      failures++;
      $display("FAIL no_hazard_rt_unused: ctrl_sel=%b pc_write=%b want 1 1", cs1, pcw1);
    end
    tick();
    uses_rt = 1;
    @(negedge clk);
    checks++;
    if (cs1 !== 1'b0 || pcw1 !== 1'b0) begin
      failures++;
      $display("FAIL hazard_rt_used: ctrl_sel=%b pc_write=%b want 0 0", cs1, pcw1);
    end
    tick();
  endtask

  task automatic test_lu_with_branch();
    int bubbles;
    do_reset();
    set_lu();
    br = 1;
    bubbles = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cs3 === 1'b0 && pcw3 === 1'b0) bubbles++;
      checks++;
      if (fl3 !== 1'b0) begin
        failures++;
        $display("FAIL lu_branch_flush_c%0d: flush=%b want 0", c, fl3);
      end
      tick();
      mem_read = 0;
    end
    checks++;
    if (bubbles != 3) begin
      failures++;
      $display("FAIL lu_branch_bubbles: got %0d want 3", bubbles);
    end
    @(negedge clk);
    checks++;
    if ({pcw3, ifw3, cs3, fl3, ph3} !== 5'b11110 || sc3 !== 4'd3) begin
      failures++;
      $display("FAIL lu_branch_then_flush: ctrl=%b sc3=%0d want 11110 3", {pcw3, ifw3, cs3, fl3, ph3}, sc3);
    end
    tick();
  endtask

  task automatic test_memwait_in_stall();
    do_reset();
    set_lu();
    tick();
    set_idle();
    mreq = 1; mrdy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({pcw3, ifw3, cs3, fl3, ph3} !== 5'b00101 || mt3 !== 1'b0) begin
        failures++;
        $display("FAIL memwait_hold_c%0d: ctrl=%b mt=%b want 00101 0", c, {pcw3, ifw3, cs3, fl3, ph3}, mt3);
      end
      tick();
    end
    mreq = 1; mrdy = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({pcw3, ifw3, cs3, fl3, ph3} !== 5'b00000 || mt3 !== 1'b1) begin
        failures++;
        $display("FAIL memwait_resume_bubble_c%0d: ctrl=%b mt=%b want 00000 1", c, {pcw3, ifw3, cs3, fl3, ph3}, mt3);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({pcw3, ifw3, cs3, fl3, ph3} !== 5'b11100 || sc3 !== 4'd7 || mt3 !== 1'b1) begin
      failures++;
      $display("FAIL memwait_done: ctrl=%b sc3=%0d mt=%b want 11100 7 1", {pcw3, ifw3, cs3, fl3, ph3}, sc3, mt3);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    br = 1;
    @(negedge clk);
    checks++;
    if (fl1 !== 1'b1 || pcw1 !== 1'b1 || ifw1 !== 1'b1 || cs1 !== 1'b1) begin
      failures++;
      $display("FAIL branch_flush: flush=%b pc_write=%b if_id_write=%b ctrl_sel=%b want 1 1 1 1", fl1, pcw1, ifw1, cs1);
    end
    tick();
    br = 0;
    @(negedge clk);
    checks++;
    if (fl1 !== 1'b0 || sc1 !== 16'd0) begin
      failures++;
      $display("FAIL branch_after: flush=%b sc1=%0d want 0 0", fl1, sc1);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mreq = 1; mrdy = 0;
    for (int c = 0; c < 20; c++) tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (sc3 !== 4'hF || sc1 !== 16'd20 || mt3 !== 1'b1 || mt1 !== 1'b0) begin
      failures++;
      $display("FAIL saturation: sc3=%0d sc1=%0d mt3=%b mt1=%b want 15 20 1 0", sc3, sc1, mt3, mt1);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e1, e3;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      mem_read = ($urandom_range(0, 1) == 1);
      ex_rt    = 5'($urandom_range(0, 3));
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      uses_rt  = ($urandom_range(0, 1) == 1);
      br       = ($urandom_range(0, 3) == 0);
      mreq     = ($urandom_range(0, 3) == 0) || (c > 300 && c < 320);
      mrdy     = ($urandom_range(0, 1) == 1) && !(c > 300 && c < 320);
      e1 = mexp(0);
      e3 = mexp(1);
      @(negedge clk);
      checks++;
      if ({pcw1, ifw1, cs1, fl1, ph1} !== e1 || sc1 !== 16'(cnt[0]) || mt1 !== to[0]) begin
        failures++;
        $display("FAIL random_cfg1_c%0d: ctrl=%b sc=%0d mt=%b want %b %0d %b",
                 c, {pcw1, ifw1, cs1, fl1, ph1}, sc1, mt1, e1, cnt[0], to[0]);
      end
      checks++;
      if ({pcw3, ifw3, cs3, fl3, ph3} !== e3 || sc3 !== 4'(cnt[1]) || mt3 !== to[1]) begin
        failures++;
        $display("FAIL random_cfg3_c%0d: ctrl=%b sc=%0d mt=%b want %b %0d %b",
                 c, {pcw3, ifw3, cs3, fl3, ph3}, sc3, mt3, e3, cnt[1], to[1]);
      end
      model_edge();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_lu_with_branch();
    test_memwait_in_stall();
    test_branch();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
